seg_scanner: RTL

Time-multiplexed driver for a bank of common-cathode 7-segment digits. It latches a packed multi-digit value, scans the digits one at a time at a programmable rate, and decodes each nibble as hex or decimal with optional blanking and leading-zero suppression. It sits between the keyboard and display logic and the board's segment and digit-enable pins, and generalises the single-digit combinational decoder to N digits with frame-synchronous, tear-free updates.

---
 rtl/seg_pkg.sv | 65 ++++++
 rtl/seg_glyph.sv | 25 ++
 rtl/seg_scanner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 7-segment display path.
//   - Segment bit order: glyph bit 0 drives segment a ... bit 6 drives segment g,
//     so a glyph word reads {g,f,e,d,c,b,a}.
//   - Glyph constants for hex digits 0-F (common-cathode, active-high).
//   - SEG_BLANK: all segments off.
//   - hex_glyph(): nibble-to-glyph lookup used by seg_glyph.
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef logic [6:0] glyph_t;

   // Segment bit positions inside a glyph word.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam glyph_t SEG_BLANK = 7'h00;

   localparam glyph_t GLYPH_0 = 7'h3F;
   localparam glyph_t GLYPH_1 = 7'h06;
   localparam glyph_t GLYPH_2 = 7'h5B;
   localparam glyph_t GLYPH_3 = 7'h4F;
   localparam glyph_t GLYPH_4 = 7'h66;
   localparam glyph_t GLYPH_5 = 7'h6D;
   localparam glyph_t GLYPH_6 = 7'h7D;
   localparam glyph_t GLYPH_7 = 7'h07;
   localparam glyph_t GLYPH_8 = 7'h7F;
   localparam glyph_t GLYPH_9 = 7'h6F;
   localparam glyph_t GLYPH_A = 7'h77;
   localparam glyph_t GLYPH_B = 7'h7C;   // lower-case b
   localparam glyph_t GLYPH_C = 7'h39;
   localparam glyph_t GLYPH_D = 7'h5E;   // lower-case d
   localparam glyph_t GLYPH_E = 7'h79;
   localparam glyph_t GLYPH_F = 7'h71;

   function automatic glyph_t hex_glyph(input logic [3:0] nib);
      glyph_t g;
      case (nib)
         4'h0: g = GLYPH_0;
         4'h1: g = GLYPH_1;
         4'h2: g = GLYPH_2;
         4'h3: g = GLYPH_3;
         4'h4: g = GLYPH_4;
         4'h5: g = GLYPH_5;
         4'h6: g = GLYPH_6;
         4'h7: g = GLYPH_7;
         4'h8: g = GLYPH_8;
         4'h9: g = GLYPH_9;
         4'hA: g = GLYPH_A;
         4'hB: g = GLYPH_B;
         4'hC: g = GLYPH_C;
         4'hD: g = GLYPH_D;
         4'hE: g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage : seg_pkg

// File: rtl/seg_glyph.sv
// -----------------------------------------------------------------------------
// seg_glyph
// Purely combinational single-digit decoder.
//   nibble  in  4  digit value
//   is_hex  in  1  1 = hex glyphs 0-F, 0 = decimal (values above 9 go dark)
//   blank   in  1  force the digit dark
//   glyph   out 7  {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg_glyph
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       is_hex,
   input  logic       blank,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = hex_glyph(nibble);
      if (blank || (!is_hex && (nibble > 4'd9))) begin
         glyph = SEG_BLANK;
      end
   end

endmodule : seg_glyph

// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
// Time-multiplexed driver for DIGITS common-cathode 7-segment digits.
// A load strobe captures the display settings into a pending set; the pending
// set is promoted to the shadow set only at the end of a frame, so a frame is
// always drawn from one consistent value.
//
// Parameters
//   DIGITS     number of digits (1..8)
//   SCAN_DIV   clock cycles each digit stays enabled (>=1)
//   BLINK_DIV  frames per blink half-period (only with SEG_SCANNER_BLINK_EN)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   load        in   capture strobe for value/is_hex/blank_mask/lz_en(/blink_mask)
//   value       in   packed nibbles, digit i = value[4i+3:4i]
//   is_hex      in   1 = hex glyphs, 0 = decimal
//   blank_mask  in   per-digit force-off
//   lz_en       in   leading-zero suppression (decimal only)
//   blink_mask  in   per-digit blink enable (only with SEG_SCANNER_BLINK_EN)
//   seg         out  {g,f,e,d,c,b,a}, registered
//   dig_sel     out  one-hot digit enable, registered
//
// Build option: define SEG_SCANNER_BLINK_EN to add the blink_mask port and the
// frame counter that blanks blinking digits during the second half-period.
// -----------------------------------------------------------------------------
module seg_scanner
   import seg_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000
`ifdef SEG_SCANNER_BLINK_EN
   ,
   parameter int BLINK_DIV = 64
`endif
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  is_hex,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic                  lz_en,
`ifdef SEG_SCANNER_BLINK_EN
   input  logic [DIGITS-1:0]     blink_mask,
`endif
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // One complete set of display settings; used for both pending and shadow.
   typedef struct packed {
      logic [4*DIGITS-1:0] value;
      logic                is_hex;
      logic [DIGITS-1:0]   blank;
      logic                lz_en;
`ifdef SEG_SCANNER_BLINK_EN
      logic [DIGITS-1:0]   blink;
`endif
   } cfg_t;

   logic [PW-1:0]     pre_reg, pre_next;
   logic [IW-1:0]     idx_reg, idx_next;
   cfg_t              pend_reg, pend_next;
   cfg_t              sh_reg, sh_next;
   cfg_t              cfg_in;
   logic [6:0]        seg_reg;
   logic [DIGITS-1:0] dig_sel_reg;

   logic              tc;
   logic              wrap;
   logic [DIGITS-1:0] zero_from;
   logic [3:0]        cur_nib;
   logic              cur_blank;
   logic              blink_off;
   logic [6:0]        glyph;

   // ---------------------------------------------------------------- scan timing
   assign tc   = (pre_reg == PW'(SCAN_DIV - 1));
   assign wrap = tc && (idx_reg == IW'(DIGITS - 1));

   always_comb begin
      pre_next = tc ? '0 : pre_reg + 1'b1;
      idx_next = idx_reg;
      if (tc) begin
         idx_next = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end
   end

   // ----------------------------------------------------------- settings capture
   always_comb begin
      cfg_in        = '0;
      cfg_in.value  = value;
      cfg_in.is_hex = is_hex;
      cfg_in.blank  = blank_mask;
      cfg_in.lz_en  = lz_en;
`ifdef SEG_SCANNER_BLINK_EN
      cfg_in.blink  = blink_mask;
`endif
   end

   // A load landing on the wrap cycle bypasses pending so it is not deferred a
   // whole extra frame.
   always_comb begin
      pend_next = load ? cfg_in : pend_reg;
      sh_next   = sh_reg;
      if (wrap) begin
         sh_next = load ? cfg_in : pend_reg;
      end
   end

   // ------------------------------------------------------- leading-zero detect
   // zero_from[i]: every nibble from digit i up to the most significant is zero.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_zero
         assign zero_from[gi] = (sh_reg.value[4*DIGITS-1:4*gi] == '0);
      end
   endgenerate

   // ------------------------------------------------------------ digit select
   always_comb begin
      cur_nib   = 4'd0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_reg == IW'(i)) begin
            cur_nib   = sh_reg.value[4*i +: 4];
            cur_blank = sh_reg.blank[i]
                      | (sh_reg.lz_en && !sh_reg.is_hex && (i > 0) && zero_from[i]);
`ifdef SEG_SCANNER_BLINK_EN
            cur_blank = cur_blank | (sh_reg.blink[i] && blink_off);
`endif
         end
      end
   end

`ifdef SEG_SCANNER_BLINK_EN
   // ------------------------------------------------------------ blink phase
   // Counts completed frames modulo 2*BLINK_DIV; the upper half is the off phase.
   localparam int FW = $clog2(2 * BLINK_DIV);

   logic [FW-1:0] frame_reg, frame_next;

   always_comb begin
      frame_next = frame_reg;
      if (wrap) begin
         frame_next = (frame_reg == FW'(2 * BLINK_DIV - 1)) ? '0 : frame_reg + 1'b1;
      end
   end

   assign blink_off = (frame_reg >= FW'(BLINK_DIV));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_reg <= '0;
      end else begin
         frame_reg <= frame_next;
      end
   end
`else
   assign blink_off = 1'b0;
`endif

   seg_glyph u_glyph (
      .nibble (cur_nib),
      .is_hex (sh_reg.is_hex),
      .blank  (cur_blank),
      .glyph  (glyph)
   );

   // ------------------------------------------------------------------ state
   // seg and dig_sel register together from the same idx so the segment pattern
   // never belongs to a different digit than the one enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_reg     <= '0;
         idx_reg     <= '0;
         pend_reg    <= '0;
         sh_reg      <= '0;
         seg_reg     <= SEG_BLANK;
         dig_sel_reg <= '0;
      end else begin
         pre_reg     <= pre_next;
         idx_reg     <= idx_next;
         pend_reg    <= pend_next;
         sh_reg      <= sh_next;
         seg_reg     <= glyph;
         dig_sel_reg <= DIGITS'(1) << idx_reg;
      end
   end

   assign seg     = seg_reg;
   assign dig_sel = dig_sel_reg;

endmodule : seg_scanner
